// File: rtl/riscv_button_scan_ctrl.sv
// Multi-button debounce controller: shared tick prescaler, per-channel debounce FSMs,
// pending event flags and a round-robin event arbiter. Long-press: RISCV_BTN_LONG_PRESS_EN.
module riscv_button_scan_ctrl #(
  parameter int unsigned NUM_BTN    = 4,
  parameter int unsigned TICK_DIV   = 10000,
  parameter int unsigned DEB_TICKS  = 20,
  parameter int unsigned HOLD_TICKS = 100
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [NUM_BTN-1:0]         btn_in,
  output logic [NUM_BTN-1:0]         debounced,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [$clog2(NUM_BTN)-1:0] evt_id,
  output logic [1:0]                 evt_type,
  output logic                       evt_overflow,
  input  logic                       clear_overflow
);

  localparam int unsigned IdW  = $clog2(NUM_BTN);
  localparam int unsigned PreW = $clog2(TICK_DIV);
`ifdef RISCV_BTN_LONG_PRESS_EN
  localparam int unsigned CntW = $clog2(HOLD_TICKS);
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_TICKS - 1);
  localparam logic [CntW-1:0] HoldPre  = CntW'(HOLD_TICKS - 2);
`else
  localparam int unsigned CntW = $clog2(DEB_TICKS);
`endif
  localparam logic [CntW-1:0] DebLast = CntW'(DEB_TICKS - 1);
  localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);

  localparam logic [1:0] EvtPress   = 2'b00;
  localparam logic [1:0] EvtRelease = 2'b01;
  localparam logic [1:0] EvtLong    = 2'b10;

  typedef enum logic [1:0] {StIdle, StPWait, StPressed, StRWait} state_e;

  logic [NUM_BTN-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [PreW-1:0]    presc_q, presc_d;
  logic               tick;

  state_e             state_q [NUM_BTN];
  state_e             state_d [NUM_BTN];
  logic [CntW-1:0]    cnt_q   [NUM_BTN];
  logic [CntW-1:0]    cnt_d   [NUM_BTN];

  logic [NUM_BTN-1:0] pend_press_q, pend_press_d, set_press, grant_press;
  logic [NUM_BTN-1:0] pend_rel_q, pend_rel_d, set_rel, grant_rel;
`ifdef RISCV_BTN_LONG_PRESS_EN
  logic [NUM_BTN-1:0] pend_long_q, pend_long_d, set_long, grant_long;
  logic [NUM_BTN-1:0] long_done_q, long_done_d;
`endif
  logic [NUM_BTN-1:0] pend_any;
  logic [NUM_BTN-1:0] drop;

  logic               evt_valid_q, evt_valid_d;
  logic [IdW-1:0]     evt_id_q, evt_id_d;
  logic [1:0]         evt_type_q, evt_type_d;
  logic [IdW-1:0]     ptr_q, ptr_d;
  logic               ovf_q, ovf_d;
  logic               slot_free, found;
  logic [IdW-1:0]     sel;

  function automatic logic [IdW-1:0] rr_idx(input logic [IdW-1:0] base, input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= NUM_BTN) s = s - NUM_BTN;
    return IdW'(s);
  endfunction

  // Synchroniser and shared prescaler
  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
    tick    = enable && (presc_q == PreLast);
    if (!enable || tick) presc_d = '0;
    else                 presc_d = presc_q + 1'b1;
  end

  // Per-channel debounce FSMs; a level change wins over a tick in the same cycle
  always_comb begin
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      set_press[i] = 1'b0;
      set_rel[i]   = 1'b0;
`ifdef RISCV_BTN_LONG_PRESS_EN
      set_long[i]    = 1'b0;
      long_done_d[i] = long_done_q[i];
`endif
      debounced[i] = (state_q[i] == StPressed) || (state_q[i] == StRWait);
      if (!enable) begin
        state_d[i] = StIdle;
        cnt_d[i]   = '0;
`ifdef RISCV_BTN_LONG_PRESS_EN
        long_done_d[i] = 1'b0;
`endif
      end else begin
        unique case (state_q[i])
          StIdle: begin
            if (sync2_q[i]) begin
              state_d[i] = StPWait;
              cnt_d[i]   = '0;
            end
          end
          StPWait: begin
            if (!sync2_q[i]) begin
              state_d[i] = StIdle;
              cnt_d[i]   = '0;
            end else if (tick) begin
              if (cnt_q[i] == DebLast) begin
                state_d[i]   = StPressed;
                cnt_d[i]     = '0;
                set_press[i] = 1'b1;
              end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
              end
            end
          end
          StPressed: begin
            if (!sync2_q[i]) begin
              state_d[i] = StRWait;
              cnt_d[i]   = '0;
            end
`ifdef RISCV_BTN_LONG_PRESS_EN
            else if (tick && (cnt_q[i] != HoldLast)) begin
              cnt_d[i] = cnt_q[i] + 1'b1;
              if ((cnt_q[i] == HoldPre) && !long_done_q[i]) begin
                set_long[i]    = 1'b1;
                long_done_d[i] = 1'b1;
              end
            end
`endif
          end
          StRWait: begin
            if (sync2_q[i]) begin
              state_d[i] = StPressed;
              cnt_d[i]   = '0;
            end else if (tick) begin
              if (cnt_q[i] == DebLast) begin
                state_d[i] = StIdle;
                cnt_d[i]   = '0;
                set_rel[i] = 1'b1;
`ifdef RISCV_BTN_LONG_PRESS_EN
                long_done_d[i] = 1'b0;
`endif
              end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
              end
            end
          end
          default: state_d[i] = StIdle;
        endcase
      end
    end
  end

  // Round-robin arbiter; ptr_q holds the first channel of the next search
  always_comb begin
    pend_any = pend_press_q | pend_rel_q;
`ifdef RISCV_BTN_LONG_PRESS_EN
    pend_any = pend_any | pend_long_q;
    grant_long = '0;
`endif
    grant_press = '0;
    grant_rel   = '0;
    found       = 1'b0;
    sel         = '0;
    for (int unsigned k = 0; k < NUM_BTN; k++) begin
      if (!found && pend_any[rr_idx(ptr_q, k)]) begin
        found = 1'b1;
        sel   = rr_idx(ptr_q, k);
      end
    end

    slot_free   = !evt_valid_q || evt_ready;
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    evt_type_d  = evt_type_q;
    ptr_d       = ptr_q;
    if (slot_free) begin
      evt_valid_d = 1'b0;
      if (found && enable) begin
        evt_valid_d = 1'b1;
        evt_id_d    = sel;
        ptr_d       = (sel == IdW'(NUM_BTN - 1)) ? '0 : sel + 1'b1;
        if (pend_press_q[sel]) begin
          evt_type_d       = EvtPress;
          grant_press[sel] = 1'b1;
        end
`ifdef RISCV_BTN_LONG_PRESS_EN
        else if (pend_long_q[sel]) begin
          evt_type_d      = EvtLong;
          grant_long[sel] = 1'b1;
        end
`endif
        else begin
          evt_type_d     = EvtRelease;
          grant_rel[sel] = 1'b1;
        end
      end
    end
  end

  // Pending flags and sticky overflow; a set on an already-pending flag is dropped
  always_comb begin
    drop = (set_press & pend_press_q & ~grant_press) | (set_rel & pend_rel_q & ~grant_rel);
`ifdef RISCV_BTN_LONG_PRESS_EN
    drop = drop | (set_long & pend_long_q & ~grant_long);
    pend_long_d = enable ? ((pend_long_q & ~grant_long) | set_long) : '0;
`endif
    pend_press_d = enable ? ((pend_press_q & ~grant_press) | set_press) : '0;
    pend_rel_d   = enable ? ((pend_rel_q & ~grant_rel) | set_rel) : '0;
    if (|drop)               ovf_d = 1'b1;
    else if (clear_overflow) ovf_d = 1'b0;
    else                     ovf_d = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      presc_q      <= '0;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
      end
      pend_press_q <= '0;
      pend_rel_q   <= '0;
`ifdef RISCV_BTN_LONG_PRESS_EN
      pend_long_q  <= '0;
      long_done_q  <= '0;
`endif
      evt_valid_q  <= 1'b0;
      evt_id_q     <= '0;
      evt_type_q   <= '0;
      ptr_q        <= '0;
      ovf_q        <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      presc_q      <= presc_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_press_q <= pend_press_d;
      pend_rel_q   <= pend_rel_d;
`ifdef RISCV_BTN_LONG_PRESS_EN
      pend_long_q  <= pend_long_d;
      long_done_q  <= long_done_d;
`endif
      evt_valid_q  <= evt_valid_d;
      evt_id_q     <= evt_id_d;
      evt_type_q   <= evt_type_d;
      ptr_q        <= ptr_d;
      ovf_q        <= ovf_d;
    end
  end

  assign evt_valid    = evt_valid_q;
  assign evt_id       = evt_id_q;
  assign evt_type     = evt_type_q;
  assign evt_overflow = ovf_q;

endmodule

// File: doc/riscv_button_scan_ctrl.md
Name: riscv_button_scan_ctrl

Overview:
Multi-button debounce controller for NUM_BTN push buttons. One prescaler produces a shared debounce tick for all channels. Each channel runs its own debounce FSM with a small tick counter. Press, release and long-press events are queued as per-channel pending flags, and a round-robin arbiter serialises them onto a single valid/ready event port read by the UART/MMIO layer.

Parameters:
NUM_BTN, 4, number of button channels (>=2)
TICK_DIV, 10000, clk cycles per shared tick (>=2)
DEB_TICKS, 20, ticks a level must stay stable to be accepted (>=2)
HOLD_TICKS, 100, ticks in PRESSED before a long-press event (>DEB_TICKS)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  0 = scanning halted
btn_in  in  NUM_BTN  raw asynchronous button levels, 1 = pressed
debounced  out  NUM_BTN  debounced level per channel
evt_valid  out  1  event slot holds an event
evt_ready  in  1  consumer accepts when evt_valid & evt_ready
evt_id  out  $clog2(NUM_BTN)  channel of event
evt_type  out  2  00 press, 01 release, 10 long-press, 11 unused
evt_overflow  out  1  sticky: an event was dropped
clear_overflow  in  1  clears evt_overflow

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous, active-high. Reset zeroes every register. All outputs are 0 after reset. The round-robin pointer resets to channel 0.
- Input synchroniser: 2-FF per bit; sync[i] lags btn_in[i] by 2 cycles.
- Prescaler: counts 0..TICK_DIV-1 while enable=1. tick=1 for exactly one cycle when count==TICK_DIV-1, then count wraps to 0.
- Per-channel FSM states:
  - IDLE: debounced=0. sync=1 -> PWAIT, cnt=0.
  - PWAIT: sync=0 -> IDLE. On tick: cnt++. When cnt reaches DEB_TICKS-1 on a tick -> PRESSED, set pend_press, cnt=0.
  - PRESSED: debounced=1. sync=0 -> RWAIT, cnt=0. On tick, cnt saturates at HOLD_TICKS-1. When it reaches that value with long_done=0: set pend_long and long_done=1.
  - RWAIT: debounced=1. sync=1 -> PRESSED, cnt=0; long_done is kept. On tick: cnt++. When cnt reaches DEB_TICKS-1 -> IDLE, set pend_release, clear long_done.
  - A level change takes priority over a tick in the same cycle.
- Acceptance latency: after sync settles, between (DEB_TICKS-1)*TICK_DIV+1 and DEB_TICKS*TICK_DIV cycles, because the tick phase is shared.
- Pending flags: 3 per channel.
  - Setting a flag that is already set and not being granted that cycle sets evt_overflow; the new event is dropped.
  - Set and grant of the same flag in the same cycle: the flag stays set, no overflow.
- Arbiter:
  - The event slot loads when empty, or when the current event is accepted in the same cycle (back-to-back, one event per cycle).
  - Channel search is round-robin starting at last_granted+1 (mod NUM_BTN).
  - Within a channel: press > long > release.
  - The granted flag clears. evt_id, evt_type and evt_valid are registered, so a flag set in cycle t appears at the earliest in cycle t+1.
  - Slot contents stay stable while evt_valid=1 and evt_ready=0.
- evt_overflow: set has priority over clear_overflow in the same cycle.
- enable=0:
  - Prescaler held at 0; all FSMs forced to IDLE, so debounced=0 next cycle.
  - Pending flags and long_done cleared.
  - The occupied event slot is kept until accepted.
- Reset mid-operation: immediate return to reset state next edge. Partially debounced levels and in-flight events are discarded.

Optional Feature:
RISCV_BTN_LONG_PRESS_EN.
- Defined: long-press detection as above.
- Undefined: no hold counting, pend_long and long_done are not implemented, evt_type 10 is never produced, HOLD_TICKS is ignored, and the cnt width is $clog2(DEB_TICKS).

Test Plan:
All scenarios use NUM_BTN=4, TICK_DIV=4, DEB_TICKS=3, HOLD_TICKS=8, enable=1, evt_ready=1 unless stated.
- Clean press: btn_in=0010 held from cycle 0 -> debounced[1] rises in cycle 11..14 (2 synchroniser cycles plus 9..12). The following cycle: evt_valid=1, evt_id=1, evt_type=00 for one cycle.
- Bounce: btn_in[0] toggles every 5 cycles for 60 cycles, then 0 -> debounced stays 0, no events.
- Simultaneous press: btn_in 0000->1001 in one cycle -> events id=0 then id=3 on consecutive cycles, both type 00.
- Backpressure: evt_ready=0; ch2 pressed/released twice -> first press held stable in slot, evt_overflow=1. clear_overflow pulse -> 0. evt_ready=1 then drains remaining pending events in priority order.
- Long press (macro defined): hold ch1 50 cycles, then release -> exactly press, long, release events in order. Macro undefined -> press, release only.
- Reset/enable: reset during PWAIT of ch3 -> all outputs 0, no event ever issued. enable=0 while ch0 PRESSED -> debounced[0]=0 next cycle, no release event.
